// File: rtl/gf256_pkg.sv
// Shared GF(2^8) definitions for the Frobenius-power unit: field width, default
// reduction polynomial, FSM states and the polynomial-basis squaring function.
package gf256_pkg;

  localparam logic [7:0] GF_POLY_AES = 8'h1B;
  localparam int         GF_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } gf_state_e;

  // Spread a_i to bit 2i, then fold bits 14..8 back down using x^8 = poly.
  function automatic logic [GF_W-1:0] gf_sq(input logic [GF_W-1:0] a,
                                            input logic [GF_W-1:0] poly);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < GF_W; i++) p[2*i] = a[i];
    for (int i = 14; i >= GF_W; i--) begin
      if (p[i]) p = p ^ ({8'h00, poly} << (i - GF_W)) ^ (16'h0001 << i);
    end
    return p[GF_W-1:0];
  endfunction

endpackage

// File: rtl/gf256_sq.sv
// Combinational GF(2^8) squarer in polynomial basis (XOR network only).
module gf256_sq
  import gf256_pkg::*;
#(
  parameter logic [GF_W-1:0] POLY = GF_POLY_AES
) (
  input  logic [GF_W-1:0] i_a,
  output logic [GF_W-1:0] o_sq
);

  assign o_sq = gf_sq(i_a, POLY);

endmodule

// File: rtl/gf256_frob_iter.sv
// GF(2^8) Frobenius power out = in^(2^K) by K squarings, one operation in flight.
// Build option GF_FROB_ONESHOT_EN: unrolled K-squarer chain, result in one edge.
module gf256_frob_iter
  import gf256_pkg::*;
#(
  parameter logic [GF_W-1:0] POLY = GF_POLY_AES,
  parameter int              K    = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [GF_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [GF_W-1:0] out_data,
  output logic            busy
);

  if (K < 0 || K > 15) begin : g_bad_k
    $error("gf256_frob_iter: K must be in 0..15");
  end

  gf_state_e       r_state, w_state_nxt;
  logic [GF_W-1:0] r_acc, w_acc_nxt;
  logic            w_accept;

  assign in_ready  = (r_state == IDLE) & ~rst;
  assign out_valid = (r_state == HOLD);
  assign out_data  = out_valid ? r_acc : '0;
  assign busy      = (r_state != IDLE);
  assign w_accept  = in_valid & in_ready;

`ifdef GF_FROB_ONESHOT_EN
  logic [GF_W-1:0] w_chain [0:K];

  assign w_chain[0] = in_data;
  for (genvar g = 0; g < K; g++) begin : g_sq
    gf256_sq #(.POLY(POLY)) u_sq (.i_a(w_chain[g]), .o_sq(w_chain[g+1]));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    case (r_state)
      IDLE: if (w_accept) begin
        w_acc_nxt   = w_chain[K];
        w_state_nxt = HOLD;
      end
      HOLD:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
    end
  end
`else
  // Last BUSY count; unused when K==0 since BUSY is never entered.
  localparam logic [3:0] KM1 = (K == 0) ? 4'd0 : 4'(K - 1);

  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [GF_W-1:0] w_sq;

  gf256_sq #(.POLY(POLY)) u_sq (.i_a(r_acc), .o_sq(w_sq));

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (w_accept) begin
        w_acc_nxt   = in_data;
        w_cnt_nxt   = '0;
        w_state_nxt = (K == 0) ? HOLD : BUSY;
      end
      BUSY: begin
        w_acc_nxt = w_sq;
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == KM1) w_state_nxt = HOLD;
      end
      HOLD:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_gf256_frob_iter.sv
// Self-checking bench for gf256_frob_iter: three instances (K=7, K=8, K=0)
// against a field-multiplication reference model.
module tb_gf256_frob_iter;
  import gf256_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] in_data   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] out_data  [3];
  logic       busy      [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gf256_frob_iter #(.POLY(8'h1B), .K(g == 0 ? 7 : (g == 1 ? 8 : 0))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .busy     (busy[g])
    );
  end

  function automatic int k_of(input int d);
    return (d == 0) ? 7 : ((d == 1) ? 8 : 0);
  endfunction

  // Edges counted including the accepting one.
  function automatic int exp_lat(input int d);
`ifdef GF_FROB_ONESHOT_EN
    return 1 + 0 * d;
`else
    return k_of(d) + 1;
`endif
  endfunction

  // Reference: general field multiply, then a^(2^k) by k self-multiplications.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, r;
    x = a; y = b; r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] frob(input logic [7:0] a, input int k);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < k; i++) r = gmul(r, r);
    return r;
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Issue one operand; with toggle, in_valid stays high with junk data while busy.
  // Returns in HOLD with out_ready low, or one edge after consumption otherwise.
  task automatic run_op(input int d, input logic [7:0] a, input bit toggle,
                        output logic [7:0] res);
    int lat;
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_data[d]  = a;
    chk1("in_ready_idle", in_ready[d], 1'b1);
    @(posedge clk); #1;
    if (!toggle) in_valid[d] = 1'b0;
    lat = 1;
    while (!out_valid[d] && lat < 40) begin
      if (toggle) in_data[d] = 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid[d] = 1'b0;
    chkn("latency", lat, exp_lat(d));
    res = out_data[d];
    if (out_ready[d]) begin
      @(posedge clk); #1;
      chk1("released", out_valid[d], 1'b0);
    end
  endtask

  initial begin
    logic [7:0] res, a, held;
    logic [7:0] vin  [5];
    logic [7:0] vout [5];
    bit         seen [256];
    int         distinct;

    vin  = '{8'h04, 8'h10, 8'h40, 8'h1B, 8'h6C};
    vout = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_data[d] = 8'h00; out_ready[d] = 1'b1;
    end

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk1("rst_in_ready", in_ready[d], 1'b0);
      chk1("rst_out_valid", out_valid[d], 1'b0);
      chk8("rst_out_data", out_data[d], 8'h00);
      chk1("rst_busy", busy[d], 1'b0);
    end
    @(negedge clk); rst = 1'b0; #1;
    for (int d = 0; d < 3; d++) chk1("post_rst_in_ready", in_ready[d], 1'b1);

    // Square roots of known powers of x
    for (int i = 0; i < 5; i++) begin
      run_op(0, vin[i], 1'b0, res);
      chk8("sqrt_vec", res, vout[i]);
      chk8("sqrt_vec_model", res, frob(vin[i], 7));
    end

    // Fixed points and the order-8 identity
    for (int d = 0; d < 2; d++) begin
      run_op(d, 8'h00, 1'b0, res); chk8("fix_00", res, 8'h00);
      run_op(d, 8'h01, 1'b0, res); chk8("fix_01", res, 8'h01);
    end
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      run_op(1, a, 1'b0, res);
      chk8("k8_identity", res, a);
      chk8("k8_model", res, frob(a, 8));
    end

    // K=0: identity, single-edge latency
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      run_op(2, a, 1'b0, res);
      chk8("k0_identity", res, a);
    end

    // Full sweep: result squares back to input, outputs form a permutation
    distinct = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      run_op(0, 8'(i), 1'b0, res);
      chk8("sweep_model", res, frob(8'(i), 7));
      chk8("sweep_roundtrip", gf_sq(res, 8'h1B), 8'(i));
      if (!seen[res]) distinct++;
      seen[res] = 1'b1;
    end
    chkn("sweep_permutation", distinct, 256);

    // Backpressure: result held, new operands refused, no accept on release edge
    out_ready[0] = 1'b0;
    a = 8'($urandom);
    run_op(0, a, 1'b0, held);
    chk8("bp_result", held, frob(a, 7));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data[0]  = 8'($urandom);
      @(posedge clk); #1;
      chk1("bp_valid", out_valid[0], 1'b1);
      chk8("bp_data", out_data[0], held);
      chk1("bp_in_ready", in_ready[0], 1'b0);
    end
    @(negedge clk); out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk1("bp_release_valid", out_valid[0], 1'b0);
    chk1("bp_release_no_accept", busy[0], 1'b0);
    in_valid[0] = 1'b0;

    // Operand changes while busy have no effect
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom);
      run_op(0, a, 1'b1, res);
      chk8("toggle_result", res, frob(a, 7));
    end

    // Reset mid-operation
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'h55;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk1("midrst_valid", out_valid[0], 1'b0);
    chk8("midrst_data", out_data[0], 8'h00);
    chk1("midrst_busy", busy[0], 1'b0);
    @(negedge clk); rst = 1'b0; out_ready[0] = 1'b1; #1;
    chk1("midrst_in_ready", in_ready[0], 1'b1);
    chk1("midrst_no_result", out_valid[0], 1'b0);
    run_op(0, 8'h04, 1'b0, res);
    chk8("midrst_next", res, 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gf256_frob_iter.md
Name: gf256_frob_iter

Overview:
- Sequential GF(2^8) Frobenius-power unit; computes out = in^(2^K) by K iterated squarings in polynomial basis.
- With the default K=7 this is the field square root, i.e. the inverse of the squaring stage used in the composite-field S-box / PRNG datapath.
- Sits between the PRNG state register and the nonlinear mixing logic.
- valid/ready on both sides; one operation in flight.

Parameters:
- POLY, 8'h1B, low 8 bits of the irreducible reduction polynomial (x^8 + POLY; default is the AES polynomial 0x11B).
- K, 7, number of squarings (0..15); K=7 gives the square root.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  unit can accept an operand
- in_data  input  8  operand a
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  8  a^(2^K)
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, busy=0.
  - in_ready is 0 while rst is high and 1 in the first cycle after.
  - Reset mid-operation aborts the operation: no result is emitted and the operand is lost.
- States: IDLE, BUSY, HOLD. in_ready = (state==IDLE) & ~rst. out_valid = (state==HOLD).
- IDLE, in_valid & in_ready at an edge: acc<=in_data, cnt<=0.
  - K>0: go BUSY.
  - K==0: go HOLD, so out_data==in_data one cycle later.
- BUSY, each edge: acc<=sq(acc), cnt<=cnt+1. When cnt==K-1, the same edge moves to HOLD.
- Latency: out_valid rises exactly K edges after the accepting edge (min 1 edge for K=0).
- HOLD: out_data=acc, held stable while out_valid & ~out_ready.
  - out_valid & out_ready at an edge: go IDLE.
  - No new operand is accepted in that edge; next accept is at the earliest one cycle later.
  - Throughput: one result per K+2 cycles with out_ready tied high.
- in_valid asserted while not in IDLE is ignored; the upstream must hold it until in_ready.
- in_data is sampled only at the accepting edge; later changes have no effect.
- sq(a): 8-bit polynomial square (a_i moves to bit 2i, 15-bit result), reduced mod x^8+POLY.
  - Purely combinational, XOR-only, no carries.
- Special values:
  - sq(0)=0 and sq(1)=1, so 0x00 and 0x01 are fixed points for any K.
  - For K=8 out==in, since the Frobenius map has order 8; this is legal and must be correct.
- cnt is 4 bits. K>15 is an elaboration error.

Optional Feature:
- Macro: GF_FROB_ONESHOT_EN.
- Defined:
  - BUSY is removed.
  - At accept, acc<=sq^K(in_data) through an unrolled chain of K squarers, and the FSM goes straight to HOLD.
  - Latency is 1 edge for all K; busy is 1 only in HOLD.
  - Result values are bit-identical to the iterative mode.
- Undefined: iterative mode as described above, with one squarer instance.

Decomposition:
- Package gf256_pkg contains:
  - localparam GF_POLY_AES = 8'h1B.
  - localparam GF_W = 8.
  - FSM state enum typedef (IDLE/BUSY/HOLD).
  - Function gf_sq(a, poly), used by both RTL and the bench model.
- One sub-module, gf256_sq: combinational squarer with POLY parameter.
  - Instantiated once in iterative mode, K times under GF_FROB_ONESHOT_EN.

Test Plan:
- K=7, POLY=0x1B, out_ready=1: inputs 0x04, 0x10, 0x40, 0x1B, 0x6C.
  - Required outputs 0x02, 0x04, 0x08, 0x10, 0x20.
  - Each out_valid exactly 7 edges after its accept.
- Fixed points (K=7 and K=8): 0x00->0x00, 0x01->0x01; K=8 with a random input returns the input.
- Round trip: all 256 inputs with K=7; check gf_sq(out_data)==in_data and outputs form a permutation.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in HOLD: out_data and out_valid stable, in_ready=0.
  - Toggle in_data while BUSY: result unaffected.
- Reset mid-BUSY (after 3 squarings): next cycle state IDLE, out_valid=0, out_data=0, in_ready=1.
  - A new operand 0x04 then yields 0x02.
- K=0 and GF_FROB_ONESHOT_EN builds (K=7): identity passes with latency 1.
  - One-shot outputs match the iterative run for the same 256-input sweep, each with latency 1.
